// File: rtl/mem_arbiter.sv
// Single-outstanding request scheduler between fetch / load-store clients and a byte-serial
// memory controller, with bounded fetch starvation and branch-flush handling.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_len,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mc_fetch_start,
    output logic [31:0] mc_pc,
    input  logic        mc_fetch_done,
    input  logic [31:0] mc_inst,
    output logic        mc_ls_start,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    output logic [2:0]  mc_len,
    input  logic        mc_ls_done,
    input  logic [31:0] mc_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_FETCH, WAIT_LS, DRAIN} state_t;

    state_t      state, state_n;
    logic        ifb_valid, ifb_valid_n;
    logic [31:0] ifb_pc, ifb_pc_n;
    logic        lsb_valid, lsb_valid_n;
    logic        lsb_wr, lsb_wr_n;
    logic [31:0] lsb_addr, lsb_addr_n;
    logic [31:0] lsb_wdata, lsb_wdata_n;
    logic [2:0]  lsb_len, lsb_len_n;
    logic [3:0]  starve_cnt, starve_n, starve_base;
    logic        cur_wr, cur_wr_n;
    logic        cur_fetch, cur_fetch_n;
    logic        if_cand, ls_cand, grant_fetch, grant_ls;

    logic        if_done_n, ls_done_n, mc_fetch_start_n, mc_ls_start_n, mc_wr_n;
    logic [31:0] if_inst_n, ls_rdata_n, mc_pc_n, mc_addr_n, mc_wdata_n;
    logic [2:0]  mc_len_n;

    always_comb begin
        state_n          = state;
        // Buffered entries survive a flush only if they are stores; same-cycle requests always win.
        if_cand          = if_req | (ifb_valid & ~flush);
        ls_cand          = ls_req | (lsb_valid & ~(flush & ~lsb_wr));
        ifb_valid_n      = if_cand;
        ifb_pc_n         = if_req ? if_pc : ifb_pc;
        lsb_valid_n      = ls_cand;
        lsb_wr_n         = ls_req ? ls_wr    : lsb_wr;
        lsb_addr_n       = ls_req ? ls_addr  : lsb_addr;
        lsb_wdata_n      = ls_req ? ls_wdata : lsb_wdata;
        lsb_len_n        = ls_req ? ls_len   : lsb_len;
        starve_base      = flush ? '0 : starve_cnt;
        starve_n         = if_cand ? starve_base : '0;
        grant_fetch      = 1'b0;
        grant_ls         = 1'b0;
        cur_wr_n         = cur_wr;
        cur_fetch_n      = cur_fetch;
        if_done_n        = 1'b0;
        ls_done_n        = 1'b0;
        mc_fetch_start_n = 1'b0;
        mc_ls_start_n    = 1'b0;
        if_inst_n        = if_inst;
        ls_rdata_n       = ls_rdata;
        mc_pc_n          = mc_pc;
        mc_wr_n          = mc_wr;
        mc_addr_n        = mc_addr;
        mc_wdata_n       = mc_wdata;
        mc_len_n         = mc_len;

        unique case (state)
            IDLE: begin
                grant_fetch = if_cand & (~ls_cand | (starve_base == LIMIT));
                grant_ls    = ls_cand & ~grant_fetch;
                if (grant_fetch) begin
                    mc_fetch_start_n = 1'b1;
                    mc_pc_n          = ifb_pc_n;
                    ifb_valid_n      = 1'b0;
                    starve_n         = '0;
                    cur_fetch_n      = 1'b1;
                    state_n          = WAIT_FETCH;
                end else if (grant_ls) begin
                    mc_ls_start_n = 1'b1;
                    mc_wr_n       = lsb_wr_n;
                    mc_addr_n     = lsb_addr_n;
                    mc_wdata_n    = lsb_wdata_n;
                    mc_len_n      = lsb_len_n;
                    lsb_valid_n   = 1'b0;
                    cur_wr_n      = lsb_wr_n;
                    cur_fetch_n   = 1'b0;
                    if (if_cand) starve_n = starve_base + 4'd1;
                    state_n       = WAIT_LS;
                end
            end
            WAIT_FETCH: begin
                // A flush coinciding with the done discards the word instead of draining.
                if (mc_fetch_done) begin
                    state_n = IDLE;
                    if (!flush) begin
                        if_done_n = 1'b1;
                        if_inst_n = mc_inst;
                    end
                end else if (flush) begin
                    state_n = DRAIN;
                end
            end
            WAIT_LS: begin
                if (mc_ls_done) begin
                    state_n = IDLE;
                    if (!(flush & ~cur_wr)) begin
                        ls_done_n  = 1'b1;
                        ls_rdata_n = cur_wr ? '0 : mc_rdata;
                    end
                end else if (flush & ~cur_wr) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cur_fetch ? mc_fetch_done : mc_ls_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ifb_valid      <= 1'b0;
            ifb_pc         <= '0;
            lsb_valid      <= 1'b0;
            lsb_wr         <= 1'b0;
            lsb_addr       <= '0;
            lsb_wdata      <= '0;
            lsb_len        <= '0;
            starve_cnt     <= '0;
            cur_wr         <= 1'b0;
            cur_fetch      <= 1'b0;
            if_done        <= 1'b0;
            if_inst        <= '0;
            ls_done        <= 1'b0;
            ls_rdata       <= '0;
            mc_fetch_start <= 1'b0;
            mc_pc          <= '0;
            mc_ls_start    <= 1'b0;
            mc_wr          <= 1'b0;
            mc_addr        <= '0;
            mc_wdata       <= '0;
            mc_len         <= '0;
        end else if (rdy) begin
            state          <= state_n;
            ifb_valid      <= ifb_valid_n;
            ifb_pc         <= ifb_pc_n;
            lsb_valid      <= lsb_valid_n;
            lsb_wr         <= lsb_wr_n;
            lsb_addr       <= lsb_addr_n;
            lsb_wdata      <= lsb_wdata_n;
            lsb_len        <= lsb_len_n;
            starve_cnt     <= starve_n;
            cur_wr         <= cur_wr_n;
            cur_fetch      <= cur_fetch_n;
            if_done        <= if_done_n;
            if_inst        <= if_inst_n;
            ls_done        <= ls_done_n;
            ls_rdata       <= ls_rdata_n;
            mc_fetch_start <= mc_fetch_start_n;
            mc_pc          <= mc_pc_n;
            mc_ls_start    <= mc_ls_start_n;
            mc_wr          <= mc_wr_n;
            mc_addr        <= mc_addr_n;
            mc_wdata       <= mc_wdata_n;
            mc_len         <= mc_len_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized phase checked against a transaction-level model
// of the arbiter's grant, completion and starvation rules.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_req, if_done;
    logic [31:0] if_pc, if_inst;
    logic        ls_req, ls_wr, ls_done;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [2:0]  ls_len;
    logic        mc_fetch_start, mc_fetch_done, mc_ls_start, mc_wr, mc_ls_done;
    logic [31:0] mc_pc, mc_inst, mc_addr, mc_wdata, mc_rdata;
    logic [2:0]  mc_len;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_pc(if_pc), .if_done(if_done), .if_inst(if_inst),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_len(ls_len), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mc_fetch_start(mc_fetch_start), .mc_pc(mc_pc), .mc_fetch_done(mc_fetch_done),
        .mc_inst(mc_inst), .mc_ls_start(mc_ls_start), .mc_wr(mc_wr), .mc_addr(mc_addr),
        .mc_wdata(mc_wdata), .mc_len(mc_len), .mc_ls_done(mc_ls_done), .mc_rdata(mc_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic complete(input bit fetch, input logic [31:0] data);
        if (fetch) begin mc_fetch_done = 1'b1; mc_inst = data; end
        else begin mc_ls_done = 1'b1; mc_rdata = data; end
        step();
        mc_fetch_done = 1'b0;
        mc_ls_done    = 1'b0;
    endtask

    task automatic load_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] len);
        ls_req = 1'b1; ls_wr = wr; ls_addr = addr; ls_wdata = wd; ls_len = len;
    endtask

    // reference-model state for the random phase
    bit          m_if_pend, m_ls_pend, m_if_out, m_ls_out, m_busy, m_busy_fetch, m_out_wr;
    logic [31:0] m_pc, m_addr, m_wdata, stub_data;
    logic        m_wr;
    logic [2:0]  m_len;
    int          m_run, cd;
    bit          sif, sls, sbusy, sdone, sdfetch, exp_f, exp_l;
    int          nstart;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_pc = '0; ls_req = 1'b0; ls_wr = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_len = '0;
        mc_fetch_done = 1'b0; mc_inst = '0; mc_ls_done = 1'b0; mc_rdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_fstart", mc_fetch_start, 0);
        chk("rst_lstart", mc_ls_start, 0);
        chk("rst_dones", {if_done, ls_done}, 0);
        chk("rst_data", if_inst | ls_rdata | mc_pc | mc_addr, 0);

        // lone fetch: req cycle 0, start cycle 1, controller done cycle 10, client done cycle 11
        if_req = 1'b1; if_pc = 32'h100;
        step();
        if_req = 1'b0;
        chk("lone_start", mc_fetch_start, 1);
        chk("lone_pc", mc_pc, 32'h100);
        step();
        chk("lone_start_pulse", mc_fetch_start, 0);
        repeat (8) step();
        chk("lone_no_early_done", if_done, 0);
        complete(1'b1, 32'hDEADBEEF);
        chk("lone_done", if_done, 1);
        chk("lone_inst", if_inst, 32'hDEADBEEF);
        step();
        chk("lone_done_pulse", if_done, 0);

        // simultaneous requests: load first, fetch two cycles after the controller done
        if_req = 1'b1; if_pc = 32'h200;
        load_req(1'b0, 32'h2000, 32'h0, 3'd4);
        step();
        if_req = 1'b0; ls_req = 1'b0;
        chk("sim_ls_first", {mc_ls_start, mc_fetch_start}, 2'b10);
        chk("sim_ls_addr", mc_addr, 32'h2000);
        chk("sim_ls_len", {mc_wr, mc_len}, {1'b0, 3'd4});
        step(); step();
        complete(1'b0, 32'hCAFEF00D);
        chk("sim_ls_done", ls_done, 1);
        chk("sim_rdata", ls_rdata, 32'hCAFEF00D);
        chk("sim_no_fetch_yet", mc_fetch_start, 0);
        step();
        chk("sim_fetch_start", mc_fetch_start, 1);
        chk("sim_fetch_pc", mc_pc, 32'h200);
        step();
        complete(1'b1, 32'h11112222);
        chk("sim_if_done", if_done, 1);
        step();

        // starvation with limit 2: LSU, LSU, FETCH, LSU
        if_req = 1'b1; if_pc = 32'h300;
        load_req(1'b0, 32'h3000, 32'h0, 3'd1);
        step();
        if_req = 1'b0; ls_req = 1'b0;
        chk("stv_g1", {mc_ls_start, mc_fetch_start, mc_addr}, {2'b10, 32'h3000});
        step();
        complete(1'b0, 32'h1);
        load_req(1'b0, 32'h3004, 32'h0, 3'd2);
        step();
        ls_req = 1'b0;
        chk("stv_g2", {mc_ls_start, mc_fetch_start, mc_addr}, {2'b10, 32'h3004});
        step();
        complete(1'b0, 32'h2);
        load_req(1'b0, 32'h3008, 32'h0, 3'd4);
        step();
        ls_req = 1'b0;
        chk("stv_g3", {mc_ls_start, mc_fetch_start, mc_pc}, {2'b01, 32'h300});
        step();
        complete(1'b1, 32'h3);
        step();
        chk("stv_g4", {mc_ls_start, mc_fetch_start, mc_addr}, {2'b10, 32'h3008});
        step();
        complete(1'b0, 32'h4);
        step();

        // flush during outstanding load, with a same-cycle new fetch
        load_req(1'b0, 32'h4000, 32'h0, 3'd4);
        step();
        ls_req = 1'b0;
        chk("fl_ld_start", mc_ls_start, 1);
        step();
        flush = 1'b1; if_req = 1'b1; if_pc = 32'h400;
        step();
        flush = 1'b0; if_req = 1'b0;
        chk("fl_ld_hold", mc_fetch_start, 0);
        step(); step();
        complete(1'b0, 32'h1234);
        chk("fl_ld_no_done", ls_done, 0);
        step();
        chk("fl_ld_fetch", {mc_fetch_start, mc_pc}, {1'b1, 32'h400});
        step();
        complete(1'b1, 32'h5555AAAA);
        chk("fl_ld_if_done", {if_done, if_inst}, {1'b1, 32'h5555AAAA});
        step();

        // flush during outstanding store, buffered fetch dropped
        load_req(1'b1, 32'h5000, 32'hA5A5, 3'd2);
        step();
        ls_req = 1'b0;
        chk("fl_st_desc", {mc_ls_start, mc_wr, mc_len, mc_wdata}, {2'b11, 3'd2, 32'hA5A5});
        if_req = 1'b1; if_pc = 32'h500;
        step();
        if_req = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        complete(1'b0, 32'hFFFFFFFF);
        chk("fl_st_done", {ls_done, ls_rdata}, {1'b1, 32'h0});
        nstart = 0;
        for (int i = 0; i < 6; i++) begin
            nstart += int'(mc_fetch_start);
            step();
        end
        chk("fl_st_dropped", nstart, 0);

        // rdy low: ignored request, then a frozen grant
        rdy = 1'b0; if_req = 1'b1; if_pc = 32'h700;
        step();
        rdy = 1'b1; if_req = 1'b0;
        step(); step();
        chk("rdy_req_ignored", mc_fetch_start, 0);
        if_req = 1'b1; if_pc = 32'h600;
        step();
        if_req = 1'b0;
        chk("rdy_start", mc_fetch_start, 1);
        rdy = 1'b0; mc_fetch_done = 1'b1; mc_inst = 32'hBAD0BAD0;
        nstart = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nstart += int'(mc_fetch_start & ~if_done);
        end
        chk("rdy_frozen", nstart, 5);
        rdy = 1'b1; mc_fetch_done = 1'b0;
        step();
        chk("rdy_resume", {mc_fetch_start, if_done}, 2'b00);
        step();
        complete(1'b1, 32'h600D600D);
        chk("rdy_done", {if_done, if_inst}, {1'b1, 32'h600D600D});
        step();

        // reset while waiting returns to idle at once
        load_req(1'b0, 32'h8000, 32'h0, 3'd4);
        step();
        ls_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_clear", {mc_ls_start, ls_done, mc_addr}, 0);
        load_req(1'b0, 32'h8004, 32'h0, 3'd4);
        step();
        ls_req = 1'b0;
        chk("rstw_idle", {mc_ls_start, mc_addr}, {1'b1, 32'h8004});
        rst = 1'b1;
        step();
        rst = 1'b0;

        // randomized phase against a transaction-level model
        m_if_pend = 0; m_ls_pend = 0; m_if_out = 0; m_ls_out = 0; m_busy = 0;
        m_busy_fetch = 0; m_out_wr = 0; m_run = 0; cd = -1; stub_data = '0;
        m_pc = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_len = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy = ($urandom_range(0, 7) != 0);
            if_req = 1'b0; ls_req = 1'b0; mc_fetch_done = 1'b0; mc_ls_done = 1'b0;
            if (!rdy) begin
                if_req = 1'($urandom_range(0, 1));
                ls_req = 1'($urandom_range(0, 1));
                if_pc  = $urandom;
            end else begin
                if (!m_if_pend && !m_if_out && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_pc = $urandom; m_if_pend = 1; m_pc = if_pc;
                end
                if (!m_ls_pend && !m_ls_out && $urandom_range(0, 1) == 0) begin
                    m_wr = 1'($urandom_range(0, 1));
                    m_addr = $urandom; m_wdata = $urandom;
                    case ($urandom_range(0, 2))
                        0: m_len = 3'd1;
                        1: m_len = 3'd2;
                        default: m_len = 3'd4;
                    endcase
                    load_req(m_wr, m_addr, m_wdata, m_len);
                    m_ls_pend = 1;
                end
                if (cd == 0) begin
                    mc_fetch_done = m_busy_fetch; mc_ls_done = ~m_busy_fetch;
                    mc_inst = stub_data; mc_rdata = stub_data;
                end
            end
            sif = m_if_pend; sls = m_ls_pend; sbusy = m_busy;
            sdone = (cd == 0) && rdy; sdfetch = m_busy_fetch;
            step();
            if (sdone) cd = -1;
            else if (cd > 0) cd--;
            if (rdy) begin
                if (!sif) m_run = 0;
                exp_f = !sbusy && sif && (!sls || m_run == int'(LIMIT));
                exp_l = !sbusy && sls && !exp_f;
                chk("rnd_fstart", mc_fetch_start, exp_f);
                chk("rnd_lstart", mc_ls_start, exp_l);
                chk("rnd_if_done", if_done, sdone && sdfetch);
                chk("rnd_ls_done", ls_done, sdone && !sdfetch);
                if (sdone) begin
                    m_busy = 0;
                    if (sdfetch) begin
                        chk("rnd_inst", if_inst, stub_data);
                        m_if_out = 0;
                    end else begin
                        chk("rnd_rdata", ls_rdata, m_out_wr ? 32'h0 : stub_data);
                        m_ls_out = 0;
                    end
                end
                if (exp_f) begin
                    chk("rnd_pc", mc_pc, m_pc);
                    m_if_pend = 0; m_if_out = 1; m_busy = 1; m_busy_fetch = 1; m_run = 0;
                    cd = $urandom_range(0, 5); stub_data = $urandom;
                end else if (exp_l) begin
                    chk("rnd_desc_addr", mc_addr, m_addr);
                    chk("rnd_desc_misc", {mc_wr, mc_len, mc_wdata}, {m_wr, m_len, m_wdata});
                    m_ls_pend = 0; m_ls_out = 1; m_busy = 1; m_busy_fetch = 0; m_out_wr = m_wr;
                    if (sif) m_run++;
                    cd = $urandom_range(0, 5); stub_data = $urandom;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Request scheduler between the pipeline's two memory clients (instruction fetch and load/store unit) and the single byte-serial memory controller. It holds each client's start pulse in a one-entry buffer and issues exactly one transaction at a time to the controller. It routes the completion pulse and data back to the originating client, bounds fetch starvation under load/store pressure, and applies branch-flush semantics: flushed fetches and loads are discarded, stores are always completed.

## Interface
Parameters:
- STARVE_LIMIT, 4, max consecutive LSU grants while a fetch is pending; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, all state and outputs hold and all inputs are ignored.
- flush  in  1  pipeline flush (mispredict), single-cycle pulse.
- if_req  in  1  fetch request pulse.
- if_pc  in  32  fetch address, valid with if_req.
- if_done  out  1  one-cycle fetch-complete pulse.
- if_inst  out  32  fetched word, valid with if_done.
- ls_req  in  1  load/store request pulse.
- ls_wr  in  1  1 = store, 0 = load, valid with ls_req.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data, little-endian.
- ls_len  in  3  access length in bytes: 1, 2 or 4.
- ls_done  out  1  one-cycle load/store-complete pulse.
- ls_rdata  out  32  load data, valid with ls_done.
- mc_fetch_start  out  1  one-cycle fetch start to controller.
- mc_pc  out  32  fetch address to controller.
- mc_fetch_done  in  1  controller fetch-complete pulse.
- mc_inst  in  32  controller fetch data.
- mc_ls_start  out  1  one-cycle load/store start to controller.
- mc_wr, mc_addr, mc_wdata, mc_len  out  1/32/32/3  load/store descriptor to controller.
- mc_ls_done  in  1  controller load/store-complete pulse.
- mc_rdata  in  32  controller load data.

## Operation
- Buffers: IFB {valid, pc} and LSB {valid, wr, addr, wdata, len}. A request pulse writes its buffer. Clients never pulse again before their own done or a flush; if they do, the new request overwrites the buffer.
- States: IDLE, WAIT_FETCH, WAIT_LS, DRAIN.
- IDLE: candidates are buffered entries plus same-cycle requests, which bypass the buffer. If no candidate, stay in IDLE. If exactly one, grant it. If both: grant LSU, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- Grant: latch the descriptor onto mc_* outputs, pulse the matching start for one cycle, clear that buffer, go to WAIT_FETCH or WAIT_LS.
- starve_cnt (4 bits): +1 on each LSU grant while a fetch is pending; cleared on any fetch grant, and cleared whenever no fetch is pending.
- WAIT_FETCH: on mc_fetch_done, register if_inst = mc_inst, pulse if_done, go to IDLE.
- WAIT_LS: on mc_ls_done, register ls_rdata = mc_rdata (store: 0), pulse ls_done, go to IDLE.
- DRAIN: wait for the matching controller done, discard its data, emit no client done, go to IDLE.
- Flush:
  - Clear IFB.
  - Clear LSB if it holds a load; keep it if it holds a store.
  - WAIT_FETCH goes to DRAIN; WAIT_LS with a load goes to DRAIN; WAIT_LS with a store is unaffected and still produces ls_done.
  - A request arriving in the same cycle as flush belongs to the new path and is captured.
  - Clear starve_cnt.
- Controller done pulses in IDLE are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, both buffers invalid, starve_cnt 0.
- Grant latency: request in cycle N with state IDLE gives start high in cycle N+1.
- Completion latency: controller done in cycle M gives client done plus data in cycle M+1, with state IDLE in M+1. The earliest next start is M+2.
- All start and done outputs are single-cycle pulses and are registered.
- rdy low: freeze. Pulses already asserted remain asserted until the next rdy-high edge.
- Reset while in WAIT_* or DRAIN: return to IDLE immediately. The controller is reset by the same rst.

## Test plan
- Lone fetch: if_req, pc=0x100, in cycle 0 → mc_fetch_start with mc_pc=0x100 in cycle 1. Stub returns mc_inst=0xDEADBEEF with done in cycle 10 → if_done with if_inst=0xDEADBEEF in cycle 11.
- Simultaneous if_req and ls_req (load 0x2000, len 4) → LSU granted first. Fetch starts 2 cycles after ls_done's source done, with the correct pc.
- Starvation, STARVE_LIMIT=2: fetch pending while ls_req is re-pulsed each time → grant order LSU, LSU, FETCH, LSU.
- Flush during an outstanding load → no ls_done. The arbiter waits for mc_ls_done, returns to IDLE, then serves the same-cycle new fetch request.
- Flush during an outstanding store, with an IF request buffered → ls_done still pulses. The buffered fetch is dropped: no mc_fetch_start follows.
- rdy low for 5 cycles across a grant → no state change and no duplicate start pulses. The sequence resumes identically once rdy rises.
